gpio_irq_ctrl: RTL and testbench
================================

# gpio_irq_ctrl

Interrupt controller downstream of `gpio_vector`. It consumes the GPIO block's `IRQ_PIN_CHANGE` and `IRQ_INT[1:0]` outputs, plus the `Data_in` bus, and latches each source into a sticky pending flag. It arbitrates the pending sources by fixed priority and presents one request at a time to the CPU over a four-phase req/ack handshake. With each request it captures a snapshot of `Data_in`, so software can read the pin state that caused the interrupt.

## Interface
- `NUM_PINS`, default 16: width of `data_in` and `snapshot`.
- `clk`  input  1  system clock; everything is on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `Enable`  input  1  block enable, active low (same sense as `gpio_vector`).
- `irq_pin_change`  input  1  from `gpio_vector` `IRQ_PIN_CHANGE`.
- `irq_int`  input  2  from `gpio_vector` `IRQ_INT`; bit0 is pin 14, bit1 is pin 15.
- `data_in`  input  NUM_PINS  from `gpio_vector` `Data_in`.
- `irq_mask`  input  3  per-source request enable: bit0 pin-change, bit1 int0, bit2 int1.
- `irq_clear`  input  3  write-one-to-clear pulses for pending and overrun, same bit order.
- `irq_ack`  input  1  CPU acknowledge.
- `irq_req`  output  1  interrupt request to CPU.
- `irq_id`  output  2  source being served: 0 pin-change, 1 int0, 2 int1, 3 none.
- `irq_pending`  output  3  sticky pending flags.
- `irq_overrun`  output  3  a new event arrived while that source was already pending.
- `snapshot`  output  NUM_PINS  `data_in` captured at request issue.

## Operation
- **Input conditioning.** Each of the 3 sources passes through a sync flop `s`, then a history flop `p`. An event is `edge = s & ~p`, i.e. a rising edge only; level-high inputs do not re-trigger.
- **Pending.** On `edge[i]`, set `pending[i]`. If `pending[i]` is already 1 and is not being cleared this cycle, also set `overrun[i]`.
- **Clearing.** `pending[i]` is cleared by `irq_clear[i]`, or by an ack of source i. `overrun[i]` is cleared only by `irq_clear[i]`.
- **Set beats clear.** If `edge[i]` coincides with a clear of `pending[i]`, pending stays 1 and overrun is not set.
- **Masking.** Masked sources still latch pending and overrun; they just never request. Request candidates are `pending & irq_mask`.
- **Priority.** int1 > int0 > pin-change.
- **FSM states:** IDLE, REQ, ACKWAIT.
  - IDLE: `irq_req=0`, `irq_id=3`. If any candidate exists, latch `irq_id` to the highest-priority candidate, latch `snapshot <= data_in`, and go to REQ.
  - REQ: `irq_req=1`; `irq_id` and `snapshot` are frozen. Mask changes or higher-priority arrivals do not preempt. When `irq_ack=1`: clear `pending[irq_id]`, drop `irq_req`, go to ACKWAIT.
  - REQ, clear case: if `irq_clear` clears `pending[irq_id]` before ack, the request stays up until acked. The ack is then a no-op on pending.
  - ACKWAIT: `irq_req=0`; `irq_id` is held. When `irq_ack=0`, go to IDLE.
- **Disable** (`Enable=1`):
  - Synchronously clear pending and overrun, set the FSM to IDLE, drive `irq_req` to 0 and `irq_id` to 3.
  - Sync and history flops keep tracking, so re-enabling with an input already high produces no event.
  - `snapshot` is held.
- **Reset** (`reset=0`, asynchronous): all flops go to 0, except `irq_id=3`. Outputs are `irq_req=0`, `irq_id=3`, `irq_pending=0`, `irq_overrun=0`, `snapshot=0`, FSM in IDLE.
  - Reset mid-handshake abandons the request. After release, the FSM is in IDLE.

## Timing
- Input rising edge sampled at clock edge k:
  - `s=1` after edge k.
  - `pending` set after edge k+1.
  - `irq_req=1` after edge k+2.
  - `snapshot` holds `data_in` as sampled at edge k+2.
- `irq_ack` sampled high at edge m: `irq_req=0` and pending cleared after edge m.
- `irq_ack` sampled low at edge n: IDLE after edge n. The next request can rise after edge n+1 at the earliest.
- Minimum request-to-request spacing is 3 cycles with single-cycle ack.
- `irq_pending` and `irq_overrun` update one cycle after the causing edge or clear.
- All outputs are registered; there is no combinational path from input to output.

## Test plan
- **Reset values:** hold `reset=0` with random inputs. Expect `irq_req=0`, `irq_id=3`, pending=000, overrun=000, `snapshot=0`.
- **Single source with snapshot:** `Enable=0`, mask=111, `data_in=16'h4000`, pulse `irq_int[0]`.
  - Expect `irq_req` rise 3 edges later, `irq_id=1`, `snapshot=16'h4000`.
  - Ack, then release ack: expect pending=000 and return to IDLE.
- **Priority:** raise `irq_pin_change` and `irq_int[1]` on the same cycle.
  - Expect first `irq_id=2`; after its handshake, `irq_id=0`.
  - No preemption when `irq_int[0]` fires during REQ of id 0; it is served next.
- **Overrun and set-over-clear:**
  - Two `irq_pin_change` pulses before ack: expect overrun=001, pending=001.
  - Edge coinciding with `irq_clear=001`: expect pending stays 1, overrun unchanged.
- **Mask and disable:**
  - mask=000 with `irq_int[1]` pulse: expect pending=100, `irq_req` stays 0. Set mask=100: expect request with id 2.
  - `Enable=1` during REQ: expect `irq_req=0`, pending=000 next cycle.
  - Re-enable with input held high: expect no event.
- **Async reset mid-handshake:** assert `reset=0` between clock edges while in REQ. Expect `irq_req=0` immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/gpio_irq_ctrl.sv
// Interrupt controller for gpio_vector: edge-detects three sources into sticky
// pending/overrun flags and serves one at a time over a four-phase req/ack.
module gpio_irq_ctrl #(
  parameter int NUM_PINS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                Enable,
  input  logic                irq_pin_change,
  input  logic [1:0]          irq_int,
  input  logic [NUM_PINS-1:0] data_in,
  input  logic [2:0]          irq_mask,
  input  logic [2:0]          irq_clear,
  input  logic                irq_ack,
  output logic                irq_req,
  output logic [1:0]          irq_id,
  output logic [2:0]          irq_pending,
  output logic [2:0]          irq_overrun,
  output logic [NUM_PINS-1:0] snapshot
);
  typedef enum logic [1:0] {IDLE, REQ, ACKWAIT} state_t;

  state_t              state, state_n;
  logic [1:0]          id_q, id_n;
  logic                req_q, req_n;
  logic [NUM_PINS-1:0] snap_q, snap_n;
  logic [2:0]          src, s, p, evt, pend, ovr, clr, ack_clr, cand;
  logic [1:0]          pick;

  assign src = {irq_int[1], irq_int[0], irq_pin_change};

  // Sync/history flops keep tracking while disabled so re-enable with a
  // high input does not fabricate an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s <= '0;
      p <= '0;
    end else begin
      s <= src;
      p <= s;
    end
  end

  assign evt = s & ~p;

  always_comb begin
    ack_clr = '0;
    if (state == REQ && irq_ack && id_q != 2'd3) ack_clr[id_q] = 1'b1;
  end

  assign clr = irq_clear | ack_clr;

  // Set beats clear; overrun only when the flag survives this cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend <= '0;
      ovr  <= '0;
    end else if (Enable) begin
      pend <= '0;
      ovr  <= '0;
    end else begin
      pend <= evt | (pend & ~clr);
      ovr  <= (ovr & ~irq_clear) | (evt & pend & ~clr);
    end
  end

  assign cand = pend & irq_mask;

  always_comb begin
    if (cand[2])      pick = 2'd2;
    else if (cand[1]) pick = 2'd1;
    else              pick = 2'd0;
  end

  always_comb begin
    state_n = state;
    id_n    = id_q;
    req_n   = req_q;
    snap_n  = snap_q;
    case (state)
      IDLE: begin
        id_n  = 2'd3;
        req_n = 1'b0;
        if (|cand) begin
          state_n = REQ;
          id_n    = pick;
          req_n   = 1'b1;
          snap_n  = data_in;
        end
      end
      REQ: begin
        req_n = 1'b1;
        if (irq_ack) begin
          state_n = ACKWAIT;
          req_n   = 1'b0;
        end
      end
      ACKWAIT: begin
        req_n = 1'b0;
        if (!irq_ack) begin
          state_n = IDLE;
          id_n    = 2'd3;
        end
      end
      default: begin
        state_n = IDLE;
        id_n    = 2'd3;
        req_n   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      id_q   <= 2'd3;
      req_q  <= 1'b0;
      snap_q <= '0;
    end else if (Enable) begin
      state <= IDLE;
      id_q  <= 2'd3;
      req_q <= 1'b0;
    end else begin
      state  <= state_n;
      id_q   <= id_n;
      req_q  <= req_n;
      snap_q <= snap_n;
    end
  end

  assign irq_req     = req_q;
  assign irq_id      = id_q;
  assign irq_pending = pend;
  assign irq_overrun = ovr;
  assign snapshot    = snap_q;
endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Directed bench for gpio_irq_ctrl: linear steps, immediate-assertion checks.
module tb_gpio_irq_ctrl;
  logic        clk = 1'b0;
  logic        reset, Enable, irq_pin_change, irq_ack, irq_req;
  logic [1:0]  irq_int, irq_id;
  logic [15:0] data_in, snapshot;
  logic [2:0]  irq_mask, irq_clear, irq_pending, irq_overrun;
  int checks = 0;
  int errors = 0;

  gpio_irq_ctrl #(.NUM_PINS(16)) dut (
    .clk(clk), .reset(reset), .Enable(Enable), .irq_pin_change(irq_pin_change),
    .irq_int(irq_int), .data_in(data_in), .irq_mask(irq_mask), .irq_clear(irq_clear),
    .irq_ack(irq_ack), .irq_req(irq_req), .irq_id(irq_id), .irq_pending(irq_pending),
    .irq_overrun(irq_overrun), .snapshot(snapshot)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic handshake();
    irq_ack = 1'b1; step(1);
    irq_ack = 1'b0; step(1);
  endtask

  initial begin
    // reset with random inputs
    reset = 1'b0;
    Enable = 1'($urandom); irq_pin_change = 1'($urandom); irq_int = 2'($urandom);
    data_in = 16'($urandom); irq_mask = 3'($urandom); irq_clear = 3'($urandom);
    irq_ack = 1'($urandom);
    step(2);
    irq_pin_change = 1'($urandom); irq_int = 2'($urandom); data_in = 16'($urandom);
    step(1);
    chk("rst_req", irq_req, 0);
    chk("rst_id", irq_id, 3);
    chk("rst_pend", irq_pending, 0);
    chk("rst_ovr", irq_overrun, 0);
    chk("rst_snap", snapshot, 0);

    Enable = 0; irq_pin_change = 0; irq_int = 0; data_in = 0;
    irq_mask = 3'b111; irq_clear = 0; irq_ack = 0;
    step(1);
    reset = 1'b1;
    step(3);

    // single source with snapshot
    data_in = 16'h4000; irq_int = 2'b01; step(1);
    irq_int = 2'b00;
    chk("single_pend_k", irq_pending, 3'b000);
    step(1);
    chk("single_pend_k1", irq_pending, 3'b010);
    chk("single_req_k1", irq_req, 0);
    step(1);
    chk("single_req", irq_req, 1);
    chk("single_id", irq_id, 1);
    chk("single_snap", snapshot, 16'h4000);
    data_in = 16'hFFFF; step(1);
    chk("single_snap_hold", snapshot, 16'h4000);
    irq_ack = 1'b1; step(1);
    chk("single_ack_req", irq_req, 0);
    chk("single_ack_pend", irq_pending, 3'b000);
    chk("single_ackwait_id", irq_id, 1);
    irq_ack = 1'b0; step(1);
    chk("single_idle_id", irq_id, 3);
    chk("single_idle_req", irq_req, 0);

    // priority: int1 over pin-change, no preemption by int0
    irq_pin_change = 1; irq_int = 2'b10; step(1);
    irq_pin_change = 0; irq_int = 2'b00; step(2);
    chk("prio_first_req", irq_req, 1);
    chk("prio_first_id", irq_id, 2);
    handshake();
    chk("prio_pend_after", irq_pending, 3'b001);
    step(1);
    chk("prio_second_req", irq_req, 1);
    chk("prio_second_id", irq_id, 0);
    irq_int = 2'b01; step(1);
    irq_int = 2'b00; step(1);
    chk("nopreempt_pend", irq_pending, 3'b011);
    chk("nopreempt_id", irq_id, 0);
    handshake();
    chk("nopreempt_pend2", irq_pending, 3'b010);
    step(1);
    chk("third_id", irq_id, 1);
    chk("third_req", irq_req, 1);
    handshake();
    chk("prio_done_pend", irq_pending, 3'b000);

    // overrun: two pin-change pulses before ack
    irq_pin_change = 1; step(1);
    irq_pin_change = 0; step(1);
    irq_pin_change = 1; step(1);
    irq_pin_change = 0; step(1);
    chk("ovr_ovr", irq_overrun, 3'b001);
    chk("ovr_pend", irq_pending, 3'b001);
    chk("ovr_id", irq_id, 0);
    handshake();
    chk("ovr_after_ack_pend", irq_pending, 3'b000);
    chk("ovr_sticky", irq_overrun, 3'b001);
    irq_clear = 3'b001; step(1);
    irq_clear = 3'b000;
    chk("ovr_cleared", irq_overrun, 3'b000);

    // set beats clear (masked so nothing is served)
    irq_mask = 3'b000;
    irq_pin_change = 1; step(1);
    irq_pin_change = 0; step(1);
    chk("soc_pend_pre", irq_pending, 3'b001);
    irq_pin_change = 1; step(1);
    irq_pin_change = 0; irq_clear = 3'b001; step(1);
    irq_clear = 3'b000;
    chk("soc_pend", irq_pending, 3'b001);
    chk("soc_ovr", irq_overrun, 3'b000);
    irq_clear = 3'b001; step(1);
    irq_clear = 3'b000;
    chk("soc_cleared", irq_pending, 3'b000);

    // mask, then disable during REQ
    irq_int = 2'b10; step(1);
    irq_int = 2'b00; step(4);
    chk("mask_pend", irq_pending, 3'b100);
    chk("mask_noreq", irq_req, 0);
    irq_mask = 3'b100; step(1);
    chk("unmask_req", irq_req, 1);
    chk("unmask_id", irq_id, 2);
    Enable = 1; step(1);
    chk("dis_req", irq_req, 0);
    chk("dis_pend", irq_pending, 3'b000);
    chk("dis_id", irq_id, 3);
    irq_mask = 3'b111;
    irq_int = 2'b10; step(3);
    Enable = 0; step(3);
    chk("reen_pend", irq_pending, 3'b000);
    chk("reen_req", irq_req, 0);
    irq_int = 2'b00; step(2);

    // async reset mid-handshake
    data_in = 16'h1234;
    irq_int = 2'b01; step(1);
    irq_int = 2'b00; step(2);
    chk("ar_req_up", irq_req, 1);
    #2 reset = 1'b0;
    #1;
    chk("ar_req", irq_req, 0);
    chk("ar_id", irq_id, 3);
    chk("ar_pend", irq_pending, 3'b000);
    chk("ar_snap", snapshot, 0);
    #2 reset = 1'b1;
    step(2);
    chk("ar_idle_req", irq_req, 0);
    chk("ar_idle_id", irq_id, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
